// File: rtl/uart_frame_parser_if.sv
// uart_frame_parser_if
// Connects a byte source and a frame consumer to uart_frame_parser.
//   data_i/valid_i    received byte and its one-cycle strobe
//   frame_valid_o     a checksum-good frame is being held
//   cmd_o/len_o       command byte and payload length of the held frame
//   rd_addr_i         payload byte index to read
//   rd_data_o         payload byte at rd_addr_i, one cycle later
//   frame_ack_i       consumer releases the held frame
//   err_o/err_code_o  error pulse and last error code (1 chk, 2 len, 3 timeout)
//   drop_o            pulse when a byte is discarded while a frame is held
// The master modport belongs to the byte source/consumer side; the parser
// uses the slave modport.
interface uart_frame_parser_if;
   logic [7:0] data_i;
   logic       valid_i;
   logic       frame_valid_o;
   logic [7:0] cmd_o;
   logic [4:0] len_o;
   logic [3:0] rd_addr_i;
   logic [7:0] rd_data_o;
   logic       frame_ack_i;
   logic       err_o;
   logic [1:0] err_code_o;
   logic       drop_o;

   modport master (
      output data_i, valid_i, rd_addr_i, frame_ack_i,
      input  frame_valid_o, cmd_o, len_o, rd_data_o, err_o, err_code_o, drop_o
   );

   modport slave (
      input  data_i, valid_i, rd_addr_i, frame_ack_i,
      output frame_valid_o, cmd_o, len_o, rd_data_o, err_o, err_code_o, drop_o
   );
endinterface

// File: rtl/uart_frame_parser.sv
// uart_frame_parser
// Parses framed byte streams of the form
//   SYNC_BYTE, CMD, LEN, LEN payload bytes, CHK   (CHK = CMD ^ LEN ^ payload)
// and holds each checksum-good frame until the consumer acknowledges it.
// Ports:
//   clock    single clock
//   reset_n  asynchronous active-low reset
//   bus      uart_frame_parser_if.slave (byte input, held-frame outputs,
//            payload read port, error/drop pulses)
module uart_frame_parser #(
   parameter logic [7:0] SYNC_BYTE      = 8'hA5,
   parameter int         MAX_LEN        = 16,
   parameter int         TIMEOUT_CLOCKS = 1024
) (
   input logic                clock,
   input logic                reset_n,
   uart_frame_parser_if.slave bus
);

   localparam int CNT_W = (TIMEOUT_CLOCKS > 2) ? $clog2(TIMEOUT_CLOCKS) : 1;
   // The timeout fires on the edge where the counter would reach
   // TIMEOUT_CLOCKS-1, so err_o appears TIMEOUT_CLOCKS-1 cycles after the
   // last accepted byte.
   localparam logic [CNT_W-1:0] TMO_LAST  = CNT_W'(TIMEOUT_CLOCKS - 2);
   localparam logic [7:0]       MAX_LEN_B = 8'(MAX_LEN);

   typedef enum logic [2:0] {
      S_IDLE,
      S_CMD,
      S_LEN,
      S_PAYLOAD,
      S_CHECK,
      S_HOLD
   } state_t;

   state_t           state_reg;
   logic [7:0]       cmd_reg;
   logic [7:0]       chk_reg;
   logic [4:0]       len_reg;
   logic [3:0]       idx_reg;
   logic [CNT_W-1:0] tmo_reg;
   logic             frame_valid_reg;
   logic [7:0]       frame_cmd_reg;
   logic [4:0]       frame_len_reg;
   logic [7:0]       rd_data_reg;
   logic             err_reg;
   logic [1:0]       err_code_reg;
   logic             drop_reg;

   // Payload buffer: plain array, written while parsing, read registered.
   logic [7:0]       buf_mem [16];

   logic             parsing;
   logic             timeout_hit;
   logic             wr_en;

   assign parsing     = (state_reg == S_CMD) || (state_reg == S_LEN) ||
                        (state_reg == S_PAYLOAD) || (state_reg == S_CHECK);
   // A byte arriving on the timeout cycle takes precedence.
   assign timeout_hit = parsing && !bus.valid_i && (tmo_reg == TMO_LAST);
   assign wr_en       = bus.valid_i && (state_reg == S_PAYLOAD);

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_reg       <= S_IDLE;
         cmd_reg         <= '0;
         chk_reg         <= '0;
         len_reg         <= '0;
         idx_reg         <= '0;
         tmo_reg         <= '0;
         frame_valid_reg <= 1'b0;
         frame_cmd_reg   <= '0;
         frame_len_reg   <= '0;
         err_reg         <= 1'b0;
         err_code_reg    <= '0;
         drop_reg        <= 1'b0;
      end else begin
         err_reg  <= 1'b0;
         drop_reg <= 1'b0;

         // Counter runs only while a frame is in progress.
         if (bus.valid_i || !parsing) begin
            tmo_reg <= '0;
         end else begin
            tmo_reg <= tmo_reg + 1'b1;
         end

         if (timeout_hit) begin
            state_reg    <= S_IDLE;
            err_reg      <= 1'b1;
            err_code_reg <= 2'd3;
         end else if (bus.valid_i) begin
            case (state_reg)
               S_IDLE: begin
                  if (bus.data_i == SYNC_BYTE) begin
                     state_reg <= S_CMD;
                  end
               end
               S_CMD: begin
                  cmd_reg   <= bus.data_i;
                  chk_reg   <= bus.data_i;
                  state_reg <= S_LEN;
               end
               S_LEN: begin
                  chk_reg <= chk_reg ^ bus.data_i;
                  idx_reg <= '0;
                  if (bus.data_i > MAX_LEN_B) begin
                     state_reg    <= S_IDLE;
                     err_reg      <= 1'b1;
                     err_code_reg <= 2'd2;
                  end else begin
                     len_reg   <= bus.data_i[4:0];
                     state_reg <= (bus.data_i == 8'd0) ? S_CHECK : S_PAYLOAD;
                  end
               end
               S_PAYLOAD: begin
                  // SYNC_BYTE is plain data here; no resynchronisation.
                  chk_reg <= chk_reg ^ bus.data_i;
                  idx_reg <= idx_reg + 1'b1;
                  if ({1'b0, idx_reg} == (len_reg - 5'd1)) begin
                     state_reg <= S_CHECK;
                  end
               end
               S_CHECK: begin
                  if (bus.data_i == chk_reg) begin
                     state_reg       <= S_HOLD;
                     frame_valid_reg <= 1'b1;
                     frame_cmd_reg   <= cmd_reg;
                     frame_len_reg   <= len_reg;
                  end else begin
                     state_reg    <= S_IDLE;
                     err_reg      <= 1'b1;
                     err_code_reg <= 2'd1;
                  end
               end
               S_HOLD: begin
                  if (bus.frame_ack_i) begin
                     // Released on this edge: the byte is judged as an
                     // IDLE byte so a new frame can start immediately.
                     frame_valid_reg <= 1'b0;
                     state_reg <= (bus.data_i == SYNC_BYTE) ? S_CMD : S_IDLE;
                  end else begin
                     drop_reg <= 1'b1;
                  end
               end
               default: state_reg <= S_IDLE;
            endcase
         end else if ((state_reg == S_HOLD) && bus.frame_ack_i) begin
            frame_valid_reg <= 1'b0;
            state_reg       <= S_IDLE;
         end
      end
   end

   always_ff @(posedge clock) begin
      if (wr_en) begin
         buf_mem[idx_reg] <= bus.data_i;
      end
   end

   // Reads outside the held frame's payload return zero.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         rd_data_reg <= '0;
      end else if (frame_valid_reg && ({1'b0, bus.rd_addr_i} < frame_len_reg)) begin
         rd_data_reg <= buf_mem[bus.rd_addr_i];
      end else begin
         rd_data_reg <= '0;
      end
   end

   assign bus.frame_valid_o = frame_valid_reg;
   assign bus.cmd_o         = frame_cmd_reg;
   assign bus.len_o         = frame_len_reg;
   assign bus.rd_data_o     = rd_data_reg;
   assign bus.err_o         = err_reg;
   assign bus.err_code_o    = err_code_reg;
   assign bus.drop_o        = drop_reg;

endmodule

// File: tb/tb_uart_frame_parser.sv
// tb_uart_frame_parser
// Directed bench for uart_frame_parser. Expected frames and expected error
// codes are queued when stimulus is driven and popped when the parser
// presents a held frame or pulses err_o.
module tb_uart_frame_parser;

   localparam logic [7:0] SYNC = 8'hA5;

   typedef struct packed {
      logic [7:0]       cmd;
      logic [4:0]       len;
      logic [15:0][7:0] data;
   } frame_t;

   logic clk;
   logic rst_n;

   uart_frame_parser_if bus ();

   uart_frame_parser dut (
      .clock   (clk),
      .reset_n (rst_n),
      .bus     (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int total  = 0;
   int passed = 0;

   frame_t           frame_q [$];
   logic [1:0]       err_q   [$];
   logic [15:0][7:0] pl;
   int               drop_cnt = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   // Error and drop monitor, sampled on the falling edge.
   logic [1:0] prev_code = 2'd0;
   logic       prev_err  = 1'b0;
   logic       prev_drop = 1'b0;
   always @(negedge clk) begin
      if (!rst_n) begin
         prev_code = 2'd0;
         prev_err  = 1'b0;
         prev_drop = 1'b0;
      end else begin
         if (bus.err_o === 1'b1) begin
            check("err_single_cycle", {31'd0, prev_err}, 0);
            check("err_expected", {31'd0, err_q.size() != 0}, 1);
            if (err_q.size() != 0) begin
               logic [1:0] exp_code;
               exp_code = err_q.pop_front();
               check("err_code", {30'd0, bus.err_code_o}, {30'd0, exp_code});
            end
         end
         if (bus.err_code_o !== prev_code) begin
            check("code_changes_only_with_err", {31'd0, bus.err_o}, 1);
         end
         if (bus.drop_o === 1'b1) begin
            drop_cnt++;
            check("drop_single_cycle", {31'd0, prev_drop}, 0);
         end
         prev_code = bus.err_code_o;
         prev_err  = bus.err_o;
         prev_drop = bus.drop_o;
      end
   end

   // One idle cycle, then a one-cycle strobe; returns 1 time unit after the
   // edge that sampled the byte.
   task automatic send_byte(input logic [7:0] b, input logic ack);
      @(posedge clk); #1;
      bus.data_i      = b;
      bus.valid_i     = 1'b1;
      bus.frame_ack_i = ack;
      @(posedge clk); #1;
      bus.valid_i     = 1'b0;
      bus.frame_ack_i = 1'b0;
      $display("byte %02h ack=%0b -> fv=%0b err=%0b code=%0d drop=%0b",
               b, ack, bus.frame_valid_o, bus.err_o, bus.err_code_o, bus.drop_o);
   endtask

   // Sends a whole frame built from pl; bad replaces CHK with its inverse.
   task automatic send_frame(input logic [7:0] cmd, input logic [4:0] len,
                             input logic bad, input logic ack);
      logic [7:0] chk;
      frame_t     f;
      chk = cmd ^ {3'd0, len};
      for (int i = 0; i < int'(len); i++) chk ^= pl[i];
      if (bad) begin
         err_q.push_back(2'd1);
      end else begin
         f.cmd  = cmd;
         f.len  = len;
         f.data = pl;
         frame_q.push_back(f);
      end
      send_byte(SYNC, ack);
      send_byte(cmd, ack);
      send_byte({3'd0, len}, ack);
      for (int i = 0; i < int'(len); i++) send_byte(pl[i], ack);
      send_byte(bad ? ~chk : chk, ack);
   endtask

   // Called right after the CHK edge: checks the held frame and its payload.
   task automatic check_held(input logic do_ack);
      frame_t f;
      f = '0;
      check("held_valid", {31'd0, bus.frame_valid_o}, 1);
      check("frame_q_size", frame_q.size(), 1);
      if (frame_q.size() != 0) f = frame_q.pop_front();
      check("held_cmd", {24'd0, bus.cmd_o}, {24'd0, f.cmd});
      check("held_len", {27'd0, bus.len_o}, {27'd0, f.len});
      for (int i = 0; i < 16; i++) begin
         bus.rd_addr_i = 4'(i);
         @(posedge clk); #1;
         check($sformatf("rd_data[%0d]", i), {24'd0, bus.rd_data_o},
               (i < int'(f.len)) ? {24'd0, f.data[i]} : 32'd0);
      end
      $display("frame cmd=%02h len=%0d checked", f.cmd, f.len);
      check("held_valid_stable", {31'd0, bus.frame_valid_o}, 1);
      if (do_ack) begin
         bus.frame_ack_i = 1'b1;
         @(posedge clk); #1;
         bus.frame_ack_i = 1'b0;
         check("ack_clears_valid", {31'd0, bus.frame_valid_o}, 0);
         bus.rd_addr_i = 4'd0;
         @(posedge clk); #1;
         check("rd_data_after_ack", {24'd0, bus.rd_data_o}, 0);
      end
   endtask

   initial begin
      int n;
      int drops_before;
      logic [7:0] cmd_before;
      logic [4:0] len_before;

      rst_n           = 1'b0;
      bus.data_i      = 8'h00;
      bus.valid_i     = 1'b0;
      bus.rd_addr_i   = 4'd0;
      bus.frame_ack_i = 1'b0;
      pl              = '0;

      repeat (3) @(posedge clk);
      #1;
      check("rst_frame_valid", {31'd0, bus.frame_valid_o}, 0);
      check("rst_cmd", {24'd0, bus.cmd_o}, 0);
      check("rst_len", {27'd0, bus.len_o}, 0);
      check("rst_rd_data", {24'd0, bus.rd_data_o}, 0);
      check("rst_err", {31'd0, bus.err_o}, 0);
      check("rst_err_code", {30'd0, bus.err_code_o}, 0);
      check("rst_drop", {31'd0, bus.drop_o}, 0);
      rst_n = 1'b1;

      // Noise in IDLE is ignored silently.
      send_byte(8'h3C, 1'b0);
      send_byte(8'hFF, 1'b1);
      check("idle_noise_valid", {31'd0, bus.frame_valid_o}, 0);

      // Basic frame 10 / 11 22 33.
      pl = '0; pl[0] = 8'h11; pl[1] = 8'h22; pl[2] = 8'h33;
      send_frame(8'h10, 5'd3, 1'b0, 1'b0);
      check_held(1'b1);

      // Same frame with a corrupted checksum.
      send_frame(8'h10, 5'd3, 1'b1, 1'b0);
      check("bad_chk_err", {31'd0, bus.err_o}, 1);
      check("bad_chk_code", {30'd0, bus.err_code_o}, 1);
      check("bad_chk_no_frame", {31'd0, bus.frame_valid_o}, 0);

      // Length 0x11 exceeds the maximum.
      send_byte(SYNC, 1'b0);
      send_byte(8'h07, 1'b0);
      err_q.push_back(2'd2);
      send_byte(8'h11, 1'b0);
      check("len_err", {31'd0, bus.err_o}, 1);
      check("len_err_code", {30'd0, bus.err_code_o}, 2);

      // Zero-length frame right after the length error.
      pl = '0;
      send_frame(8'h07, 5'd0, 1'b0, 1'b0);
      check_held(1'b1);

      // Maximum length with SYNC as payload data; ack held during parsing
      // must be ignored.
      for (int i = 0; i < 16; i++) pl[i] = 8'($urandom);
      pl[5] = SYNC;
      send_frame(8'hC3, 5'd16, 1'b0, 1'b1);
      check_held(1'b1);

      // Inter-byte timeout after CMD.
      send_byte(SYNC, 1'b0);
      err_q.push_back(2'd3);
      send_byte(8'h10, 1'b0);
      n = 0;
      for (int i = 1; i <= 2000; i++) begin
         @(posedge clk); #1;
         if (bus.err_o === 1'b1) begin
            n = i;
            break;
         end
      end
      $display("timeout after %0d cycles", n);
      check("timeout_cycles", n, 1023);
      check("timeout_code", {30'd0, bus.err_code_o}, 3);

      pl = '0; pl[0] = 8'h5A; pl[1] = 8'h01;
      send_frame(8'h42, 5'd2, 1'b0, 1'b0);
      check_held(1'b1);

      // A byte on the timeout cycle wins over the timeout.
      send_byte(SYNC, 1'b0);
      send_byte(8'h10, 1'b0);
      repeat (1021) @(posedge clk);
      #1;
      begin
         frame_t f;
         f = '0; f.cmd = 8'h10; f.len = 5'd0;
         frame_q.push_back(f);
      end
      send_byte(8'h00, 1'b0);
      check("late_byte_no_err", {31'd0, bus.err_o}, 0);
      send_byte(8'h10, 1'b0);
      check_held(1'b1);

      // Held frame: stray bytes are dropped, outputs unchanged.
      pl = '0; pl[0] = SYNC; pl[1] = 8'h3C;
      send_frame(8'h5A, 5'd2, 1'b0, 1'b0);
      check_held(1'b0);
      drops_before = drop_cnt;
      cmd_before   = bus.cmd_o;
      len_before   = bus.len_o;
      send_byte(8'h77, 1'b0);
      check("drop_1", {31'd0, bus.drop_o}, 1);
      send_byte(SYNC, 1'b0);
      check("drop_2", {31'd0, bus.drop_o}, 1);
      @(posedge clk); #1;
      check("drop_count", drop_cnt - drops_before, 2);
      check("hold_valid_kept", {31'd0, bus.frame_valid_o}, 1);
      check("hold_cmd_kept", {24'd0, bus.cmd_o}, {24'd0, cmd_before});
      check("hold_len_kept", {27'd0, bus.len_o}, {27'd0, len_before});

      // Ack coincident with SYNC starts the next frame directly.
      pl = '0; pl[0] = 8'hDE; pl[1] = 8'hAD; pl[2] = 8'hBE; pl[3] = 8'hEF;
      send_frame(8'h99, 5'd4, 1'b0, 1'b1);
      check("ack_sync_no_drop", drop_cnt - drops_before, 2);
      check_held(1'b1);

      // Reset in the middle of a payload.
      send_byte(SYNC, 1'b0);
      send_byte(8'h20, 1'b0);
      send_byte(8'h04, 1'b0);
      send_byte(8'h01, 1'b0);
      send_byte(8'h02, 1'b0);
      #3 rst_n = 1'b0;
      #2;
      check("midrst_valid", {31'd0, bus.frame_valid_o}, 0);
      check("midrst_cmd", {24'd0, bus.cmd_o}, 0);
      check("midrst_len", {27'd0, bus.len_o}, 0);
      check("midrst_err", {31'd0, bus.err_o}, 0);
      check("midrst_code", {30'd0, bus.err_code_o}, 0);
      check("midrst_rd_data", {24'd0, bus.rd_data_o}, 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      pl = '0; pl[0] = 8'h01; pl[1] = 8'h02; pl[2] = 8'h03;
      send_frame(8'h21, 5'd3, 1'b0, 1'b0);
      check_held(1'b1);

      repeat (3) @(posedge clk);
      #1;
      check("err_q_drained", err_q.size(), 0);
      check("frame_q_drained", frame_q.size(), 0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
